// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg -- shared definitions for the execute-stage divide sequencer.
//
// Global defines used across the execute stage:
//   `N_REG       architectural register width
//   `N_ALU_OP    width of the ALU op-code field
//   `RST_ENABLE  active level of the reset input
//
// Package contents:
//   div_state_t  sequencer state (IDLE, RUN, DONE)
//   DIV_ITER     number of RUN iterations (one quotient bit each)
//   EXE_DIV_OP / EXE_DIVU_OP  op codes that select the divide resource
// ---------------------------------------------------------------------------
`ifndef EX_DEFINES_DONE
`define EX_DEFINES_DONE
`define N_REG      32
`define N_ALU_OP   5
`define RST_ENABLE 1'b0
`endif

package ex_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_ITER = `N_REG;

   localparam logic [`N_ALU_OP-1:0] EXE_DIV_OP  = 5'd10;
   localparam logic [`N_ALU_OP-1:0] EXE_DIVU_OP = 5'd11;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// ---------------------------------------------------------------------------
// div_step -- one combinational restoring-division step.
//
// Ports:
//   rem_in   partial remainder (always < divisor)
//   bit_in   next dividend bit, MSB first
//   divisor  divisor magnitude
//   rem_out  new partial remainder
//   q_bit    quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
   parameter int DATA_W = `N_REG
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic              bit_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_out,
   output logic              q_bit
);

   // One extra bit so the shifted remainder cannot overflow; the top bit of
   // the difference is the borrow of the trial subtraction.
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[DATA_W];
   assign rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/ex_div_seq.sv
// ---------------------------------------------------------------------------
// ex_div_seq -- iterative restoring radix-2 divide sequencer for the execute
// stage. Produces one quotient bit per RUN cycle, stalls the pipeline while
// iterating and presents quotient/remainder with a one-cycle done pulse.
//
// Optional feature macro: DIV_EARLY_EXIT_EN -- when defined, a divisor whose
// magnitude exceeds the dividend magnitude finishes straight from IDLE.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_start, i_signed   request (sampled in IDLE), 1 = DIV, 0 = DIVU
//   i_dividend/divisor  operands, sampled on accept
//   i_cancel            flush: abort any operation in progress
//   o_busy              state != IDLE
//   o_stall_req         combinational pipeline hold request
//   o_done              one-cycle completion pulse (registered)
//   o_quotient/o_remainder/o_div_zero  results, held until the next done
// ---------------------------------------------------------------------------
module ex_div_seq
   import ex_pkg::*;
#(
   parameter  int DATA_W = `N_REG,
   localparam int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_signed,
   input  logic [DATA_W-1:0] i_dividend,
   input  logic [DATA_W-1:0] i_divisor,
   input  logic              i_cancel,
   output logic              o_busy,
   output logic              o_stall_req,
   output logic              o_done,
   output logic [DATA_W-1:0] o_quotient,
   output logic [DATA_W-1:0] o_remainder,
   output logic              o_div_zero
);

   div_state_t        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] dvd_reg;    // dividend bits shift out, quotient bits shift in
   logic [DATA_W-1:0] dvs_reg;
   logic [DATA_W-1:0] rem_reg;
   logic              neg_q_reg;
   logic              neg_r_reg;
   logic [DATA_W-1:0] quo_out_reg;
   logic [DATA_W-1:0] rem_out_reg;
   logic              dz_reg;
   logic              done_reg;

   logic              accept;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W-1:0] step_rem;
   logic              step_q;
   logic [DATA_W-1:0] quo_raw;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;
   logic              last_iter;

   assign accept = (state_reg == IDLE) && i_start && !i_cancel;

   // Magnitudes wrap modulo 2^DATA_W, so -2^(DATA_W-1) stays 0x80..0 and the
   // unsigned datapath still produces the wrapped result.
   assign a_mag = (i_signed && i_dividend[DATA_W-1]) ? -i_dividend : i_dividend;
   assign b_mag = (i_signed && i_divisor[DATA_W-1])  ? -i_divisor  : i_divisor;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_in  (rem_reg),
      .bit_in  (dvd_reg[DATA_W-1]),
      .divisor (dvs_reg),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   assign quo_raw   = {dvd_reg[DATA_W-2:0], step_q};
   assign quo_fix   = neg_q_reg ? -quo_raw  : quo_raw;
   assign rem_fix   = neg_r_reg ? -step_rem : step_rem;
   assign last_iter = (cnt_reg == CNT_W'(DIV_ITER - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         dvd_reg     <= '0;
         dvs_reg     <= '0;
         rem_reg     <= '0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         quo_out_reg <= '0;
         rem_out_reg <= '0;
         dz_reg      <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  dvd_reg   <= a_mag;
                  dvs_reg   <= b_mag;
                  rem_reg   <= '0;
                  cnt_reg   <= '0;
                  neg_q_reg <= i_signed & (i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1]);
                  neg_r_reg <= i_signed & i_dividend[DATA_W-1];
                  if (i_divisor == '0) begin
                     state_reg   <= DONE;
                     done_reg    <= 1'b1;
                     quo_out_reg <= '1;
                     rem_out_reg <= i_dividend;
                     dz_reg      <= 1'b1;
                  end
`ifdef DIV_EARLY_EXIT_EN
                  else if (b_mag > a_mag) begin
                     // Quotient is zero and the dividend is already the
                     // correctly signed remainder.
                     state_reg   <= DONE;
                     done_reg    <= 1'b1;
                     quo_out_reg <= '0;
                     rem_out_reg <= i_dividend;
                     dz_reg      <= 1'b0;
                  end
`endif
                  else begin
                     state_reg <= RUN;
                  end
               end
            end
            RUN: begin
               if (i_cancel) begin
                  state_reg <= IDLE;
               end else begin
                  dvd_reg <= quo_raw;
                  rem_reg <= step_rem;
                  cnt_reg <= cnt_reg + 1'b1;
                  if (last_iter) begin
                     state_reg   <= DONE;
                     done_reg    <= 1'b1;
                     quo_out_reg <= quo_fix;
                     rem_out_reg <= rem_fix;
                     dz_reg      <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign o_busy      = (state_reg != IDLE);
   assign o_stall_req = accept || (state_reg == RUN);
   assign o_done      = done_reg;
   assign o_quotient  = quo_out_reg;
   assign o_remainder = rem_out_reg;
   assign o_div_zero  = dz_reg;

endmodule
